// File: rtl/sha256_core_ctrl.sv
// Sequencer for the SHA-256 message-expansion (rME) and compression rounds.
// Loads 16 words per block, runs 64 rounds, then updates H and chains or finishes.
module sha256_core_ctrl #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LOAD_WORDS = 16,
   parameter int unsigned ROUNDS     = 64,
   parameter int unsigned BLK_CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid_in,
   input  logic                  last_in,
   output logic                  data_ready_out,
   output logic [2:0]            FSM_core_out,
   output logic [6:0]            core_count_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  init_h_out,
   output logic                  round_dv_out,
   output logic                  hv_update_out,
   output logic                  busy_out,
   output logic                  done_out,
   output logic [BLK_CNT_W-1:0]  blk_count_out
);

   // Encodings are the rME FSM_core_in codes, so the state register drives it directly.
   typedef enum logic [2:0] {
      StIdle   = 3'b000,
      StLoad   = 3'b010,
      StRun    = 3'b011,
      StUpdate = 3'b100,
      StDone   = 3'b101
   } state_e;

   state_e                state_q, state_d;
   logic [4:0]            wcnt_q, wcnt_d;
   logic                  last_q, last_d;
   logic [6:0]            count_q, count_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [BLK_CNT_W-1:0]  blk_q, blk_d;
   logic                  init_h_q, init_h_d;
   logic                  hv_q, hv_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic                  accept;

   assign data_ready_out = (state_q == StLoad) && (wcnt_q < 5'(LOAD_WORDS));
   assign accept         = data_ready_out && data_valid_in;

   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      last_d   = last_q;
      count_d  = count_q;
      data_d   = data_q;
      blk_d    = blk_q;
      init_h_d = 1'b0;
      hv_d     = 1'b0;
      done_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_in) begin
               state_d  = StLoad;
               init_h_d = 1'b1;
               blk_d    = '0;
               wcnt_d   = '0;
               count_d  = '0;
               last_d   = 1'b0;
            end
         end
         StLoad: begin
            if (accept) begin
               data_d  = data_in;
               count_d = 7'(wcnt_q);
               wcnt_d  = wcnt_q + 5'd1;
               if (wcnt_q == 5'(LOAD_WORDS - 1)) begin
                  last_d = last_in;
               end
            end else if (wcnt_q == 5'(LOAD_WORDS)) begin
               state_d = StRun;
               count_d = '0;
            end
         end
         StRun: begin
            if (count_q == 7'(ROUNDS - 1)) begin
               state_d = StUpdate;
               hv_d    = 1'b1;
            end else begin
               count_d = count_q + 7'd1;
            end
         end
         StUpdate: begin
            blk_d = blk_q + 1'b1;
            if (last_q) begin
               state_d = StDone;
               done_d  = 1'b1;
            end else begin
               // Chain straight into the next block; H already holds the running digest.
               state_d = StLoad;
               wcnt_d  = '0;
               count_d = '0;
               last_d  = 1'b0;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         wcnt_q   <= '0;
         last_q   <= 1'b0;
         count_q  <= '0;
         data_q   <= '0;
         blk_q    <= '0;
         init_h_q <= 1'b0;
         hv_q     <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         last_q   <= last_d;
         count_q  <= count_d;
         data_q   <= data_d;
         blk_q    <= blk_d;
         init_h_q <= init_h_d;
         hv_q     <= hv_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign FSM_core_out   = state_q;
   assign core_count_out = count_q;
   assign data_out       = data_q;
   assign init_h_out     = init_h_q;
   assign round_dv_out   = (state_q == StRun);
   assign hv_update_out  = hv_q;
   assign busy_out       = busy_q;
   assign done_out       = done_q;
   assign blk_count_out  = blk_q;

endmodule

// File: doc/sha256_core_ctrl.md
Name: sha256_core_ctrl

Overview:
- Sequencing controller for the SHA-256 message-expansion datapath (rME) and the compression round logic.
- Accepts a stream of 32-bit message words per 512-bit block over a valid/ready handshake and drives rME's FSM_core_in, core_count_in and data_in.
- Runs the 64 expansion/compression rounds, then issues hash-init, hash-update and done strobes.
- Handles multi-block messages; the last block is flagged on its final word.

Parameters:
- DATA_WIDTH, 32, message word width
- LOAD_WORDS, 16, words per block; counter logic assumes 16
- ROUNDS, 64, rounds per block
- BLK_CNT_W, 16, width of the processed-block counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_in  in  1  begin a new message; sampled only in IDLE
- data_in  in  DATA_WIDTH  message word
- data_valid_in  in  1  data_in is valid
- last_in  in  1  current block is the final block; sampled only with word 15
- data_ready_out  out  1  controller accepts a word this cycle
- FSM_core_out  out  3  to rME FSM_core_in: IDLE 3'b000, LOAD 3'b010, RUN 3'b011, UPDATE 3'b100, DONE 3'b101
- core_count_out  out  7  to rME core_count_in: word index in LOAD, round index in RUN
- data_out  out  DATA_WIDTH  to rME data_in: last accepted word
- init_h_out  out  1  one-cycle pulse; load IV into the hash registers
- round_dv_out  out  1  high in RUN; compression round is valid
- hv_update_out  out  1  one-cycle pulse; add working vars into H
- busy_out  out  1  high whenever state is not IDLE
- done_out  out  1  one-cycle pulse; digest is final
- blk_count_out  out  BLK_CNT_W  blocks completed since the last start

Behaviour:
- Reset (asynchronous, any state) forces IDLE, with these output values:
  - FSM_core_out=000, core_count_out=0, data_out=0, blk_count_out=0
  - all strobes, busy_out and data_ready_out =0
  - internal word counter wcnt=0, last flag=0
- All outputs are registered except data_ready_out = (state==LOAD && wcnt<16).
- IDLE:
  - start_in=1 → LOAD; init_h_out high during the first LOAD cycle only; blk_count_out cleared; wcnt=0.
  - start_in in any other state is ignored.
- LOAD:
  - A word is accepted on an edge where data_valid_in && data_ready_out.
  - On acceptance: data_out←data_in, core_count_out←wcnt, wcnt++.
  - On word 15: last flag←last_in.
  - No valid word: data_out and core_count_out hold, so rME rewrites the same index with the same data (harmless).
  - wcnt==16: ready low; next edge → RUN with core_count_out=0. The cycle showing LOAD/15 is always visible for exactly one cycle before RUN.
- RUN:
  - core_count_out increments every cycle, 0..63, with no stall.
  - At count 63 → UPDATE.
  - data_out holds.
- UPDATE:
  - One cycle; hv_update_out=1; blk_count_out increments on exit, wrapping modulo 2^BLK_CNT_W.
  - last flag=1 → DONE.
  - last flag=0 → LOAD with wcnt=0 and no init_h_out (chaining).
- DONE: one cycle; done_out=1; → IDLE; blk_count_out holds until the next start.
- Latency, single block, data always valid, start sampled at edge E0:
  - words accepted E1..E16
  - RUN cycles follow E17..E80
  - UPDATE after E81
  - done_out after E82
  - IDLE after E83
- Stalls in LOAD extend the latency cycle for cycle; RUN length is fixed.
- Simultaneous data_valid_in with start_in in IDLE: the word is not accepted (ready is low in IDLE).

Test Plan:
- Reset then start, feed "abc" block (61626380, 0×14, 00000018) with last_in=1 on word 15, valid every cycle:
  - FSM_core_out sequence 000→010(×17)→011(×64)→100→101→000
  - core_count_out 0..15 then 0..63
  - init_h_out and done_out single pulses; blk_count_out=1
- Same block with data_valid_in deasserted for 3 cycles after word 5:
  - data_ready_out stays 1 during the gap
  - core_count_out holds 5, data_out holds 00000000
  - done_out arrives 3 cycles later than in the first scenario
- Two-block message, last_in=0 on block 1 and 1 on block 2:
  - after the first UPDATE, state returns to 010 with no init_h_out
  - hv_update_out pulses twice, done_out once, blk_count_out=2
- Assert rst at RUN round 30:
  - all outputs return to reset values immediately, without waiting for a clock edge
  - a new start completes one block normally
- Pulse start_in during RUN and hold data_valid_in=1 in IDLE with no start:
  - no state change, data_ready_out=0, no word accepted
- Hold start_in=1 continuously across DONE:
  - a new message begins on the cycle after returning to IDLE
  - blk_count_out cleared to 0, init_h_out pulses again
